// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiply sequencer.
// Executes MUL, MLA, UMULL and SMULL over WIDTH-bit operands
// (WIDTH >= 4) with a start/busy/done handshake. One multiplier bit
// is consumed per CALC cycle, so latency is fixed at WIDTH+2 cycles
// from the sampling edge of start to done, independent of the data.
// Results and N/Z flags are registered in FIN and held until the next
// FIN or reset.

module mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_n,
   output logic             flag_z
);

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MLA   = 2'b01,
      OP_UMULL = 2'b10,
      OP_SMULL = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN,
      S_DONE
   } state_t;

   state_t             state;
   op_t                op_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic               neg;
   logic [CW-1:0]      cnt;

   // Operand magnitudes presented at capture time.
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               sign_neg;

   // FIN-stage result values.
   logic               is_long;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   lo_fin;
   logic [WIDTH-1:0]   hi_fin;
   logic               n_fin;
   logic               z_fin;

   // Operand conditioning: SMULL works on magnitudes and remembers the
   // product sign. The magnitude of -2^(W-1) wraps back to 2^(W-1),
   // which is correct when the register is read as unsigned.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path leaves a value unassigned and no latch is inferred.
      a_mag    = a;
      b_mag    = b;
      sign_neg = 1'b0;
      if (op_t'(op) == OP_SMULL) begin
         a_mag    = a[WIDTH-1] ? -a : a;
         b_mag    = b[WIDTH-1] ? -b : b;
         sign_neg = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   // Result finishing: sign restore for SMULL, addend for MLA, and the
   // flags derived from exactly the halves that will be presented.
   always_comb begin
      is_long  = (op_q == OP_UMULL) || (op_q == OP_SMULL);
      prod_fix = prod;
      if (op_q == OP_SMULL && neg) begin
         prod_fix = -prod;
      end
      lo_fin = prod_fix[WIDTH-1:0];
      if (op_q == OP_MLA) begin
         lo_fin = prod_fix[WIDTH-1:0] + acc_q;
      end
      hi_fin = is_long ? prod_fix[2*WIDTH-1:WIDTH] : '0;
      n_fin  = is_long ? hi_fin[WIDTH-1] : lo_fin[WIDTH-1];
      z_fin  = (hi_fin == '0) && (lo_fin == '0);
   end

   // Control FSM and datapath; all outputs are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: state changes use non-blocking assignments so every
         // register samples the values from before this edge.
         state     <= S_IDLE;
         op_q      <= OP_MUL;
         acc_q     <= '0;
         mplier    <= '0;
         mcand     <= '0;
         prod      <= '0;
         neg       <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_q   <= op_t'(op);
                  acc_q  <= acc;
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  neg    <= sign_neg;
                  prod   <= '0;
                  cnt    <= CW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= S_CALC;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_CALC: begin
               if (mplier[0]) begin
                  prod <= prod + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= S_FIN;
               end
            end

            S_FIN: begin
               result_lo <= lo_fin;
               result_hi <= hi_fin;
               flag_n    <= n_fin;
               flag_z    <= z_fin;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= S_DONE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq at WIDTH=32.
// Cycle numbering: the edge that samples start ends cycle 0; cycle k
// is the period after the k-th following edge, so done is expected in
// cycle 34 and busy in cycles 1..33.

module tb_mul_seq;

   localparam int W = 32;

   localparam logic [1:0] MUL   = 2'b00;
   localparam logic [1:0] MLA   = 2'b01;
   localparam logic [1:0] UMULL = 2'b10;
   localparam logic [1:0] SMULL = 2'b11;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] acc;
   logic         busy;
   logic         done;
   logic [W-1:0] result_lo;
   logic [W-1:0] result_hi;
   logic         flag_n;
   logic         flag_z;

   int total = 0;
   int bad   = 0;

   mul_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc       (acc),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flag_n    (flag_n),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present a request and step to cycle 1 (just after the sampling edge).
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] xa,
                           input logic [W-1:0] xb, input logic [W-1:0] xacc,
                           input bit hold);
      @(negedge clk);
      op    = o;
      a     = xa;
      b     = xb;
      acc   = xacc;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Run one operation and check latency, busy profile, done count,
   // results, flags and output hold. pulse_cyc > 0 raises a stray start
   // (with different operands) in that cycle.
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] xacc, input int pulse_cyc,
                         input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                         input logic e_n, input logic e_z);
      int          lat = 0;
      int          dones = 0;
      int          busy_bad = 0;
      logic [63:0] obs_res = 'x;
      logic [1:0]  obs_nz = 'x;
      start_op(o, xa, xb, xacc, 1'b0);
      for (int cyc = 1; cyc <= W + 6; cyc++) begin
         if (done === 1'b1) begin
            dones++;
            if (lat == 0) begin
               lat     = cyc;
               obs_res = {result_hi, result_lo};
               obs_nz  = {flag_n, flag_z};
            end
         end
         if (busy !== (cyc <= W + 1)) busy_bad++;
         if (pulse_cyc != 0 && cyc == pulse_cyc) begin
            start = 1'b1;
            op    = UMULL;
            a     = 32'hDEAD_BEEF;
            b     = 32'h1234_5678;
            acc   = 32'hFFFF_FFFF;
         end else if (pulse_cyc != 0 && cyc == pulse_cyc + 1) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      check({tag, " latency"}, 64'(lat), 64'(W + 2));
      check({tag, " done_count"}, 64'(dones), 64'd1);
      check({tag, " busy_profile"}, 64'(busy_bad), 64'd0);
      check({tag, " result"}, obs_res, {e_hi, e_lo});
      check({tag, " flags_nz"}, 64'(obs_nz), 64'({e_n, e_z}));
      check({tag, " held"}, {result_hi, result_lo}, {e_hi, e_lo});
   endtask

   initial begin : stim
      int d1;
      int d2;
      int dones;
      logic [63:0] first_res;
      logic [63:0] second_res;
      logic [1:0]  second_nz;

      reset = 1'b1;
      start = 1'b0;
      op    = MUL;
      a     = '0;
      b     = '0;
      acc   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {busy, done, flag_n, flag_z, result_hi, result_lo}, 64'd0);
      reset = 1'b0;

      // Main function across the four ops and the flag corners.
      run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'd0, 0,
             32'h0, 32'd42, 1'b0, 1'b0);
      run_op("umull_max", UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
      run_op("smull_m1x2", SMULL, 32'hFFFF_FFFF, 32'd2, 32'd0, 0,
             32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
      run_op("smull_min", SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0, 0,
             32'h4000_0000, 32'h0, 1'b0, 1'b0);
      run_op("mla_3x4p5", MLA, 32'd3, 32'd4, 32'd5, 0,
             32'h0, 32'd17, 1'b0, 1'b0);
      run_op("mul_zero", MUL, 32'd0, 32'h1234, 32'd0, 0,
             32'h0, 32'h0, 1'b0, 1'b1);
      // 2^16 * 2^16 = 2^32 truncates to 0 for MLA; hi stays 0.
      run_op("mla_wrap", MLA, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 0,
             32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("mul_neg_flag", MUL, 32'h8000_0000, 32'd1, 32'd0, 0,
             32'h0, 32'h8000_0000, 1'b1, 1'b0);
      // Negative sign but zero magnitude must still read as zero.
      run_op("smull_zero", SMULL, 32'd0, 32'hFFFF_FFFB, 32'd0, 0,
             32'h0, 32'h0, 1'b0, 1'b1);
      // Stray start in cycle 10 of a busy op is ignored.
      run_op("mul_ignore_start", MUL, 32'd7, 32'd6, 32'd0, 10,
             32'h0, 32'd42, 1'b0, 1'b0);

      // Back-to-back: start held through DONE; operands changed during
      // CALC only reach the second op.
      d1 = 0;
      d2 = 0;
      dones = 0;
      first_res  = 'x;
      second_res = 'x;
      second_nz  = 'x;
      start_op(MUL, 32'd7, 32'd6, 32'd0, 1'b1);
      for (int cyc = 1; cyc <= 2 * (W + 2) + 4; cyc++) begin
         if (done === 1'b1) begin
            dones++;
            if (d1 == 0) begin
               d1 = cyc;
               first_res = {result_hi, result_lo};
            end else if (d2 == 0) begin
               d2 = cyc;
               second_res = {result_hi, result_lo};
               second_nz  = {flag_n, flag_z};
            end
         end
         if (cyc == 1) begin
            op  = UMULL;
            a   = 32'hFFFF_FFFF;
            b   = 32'hFFFF_FFFF;
            acc = 32'd9;
         end
         if (cyc == W + 3) start = 1'b0;
         if (cyc == W + 3) check("b2b busy_restart", 64'(busy), 64'd1);
         if (cyc == W + 8) check("b2b hold_during_calc", {result_hi, result_lo}, 64'd42);
         @(posedge clk);
         #1;
      end
      check("b2b first_latency", 64'(d1), 64'(W + 2));
      check("b2b first_result", first_res, 64'd42);
      check("b2b spacing", 64'(d2 - d1), 64'(W + 2));
      check("b2b done_count", 64'(dones), 64'd2);
      check("b2b second_result", second_res, 64'hFFFF_FFFE_0000_0001);
      check("b2b second_flags", 64'(second_nz), 64'b10);

      // Reset in cycle 15 of CALC, with start also high: back to IDLE,
      // outputs cleared, no done.
      dones = 0;
      start_op(MUL, 32'd7, 32'd6, 32'd0, 1'b0);
      for (int cyc = 1; cyc <= W + 10; cyc++) begin
         if (done === 1'b1) dones++;
         if (cyc == 16) begin
            check("reset_mid_outputs",
                  {busy, done, flag_n, flag_z, result_hi, result_lo}, 64'd0);
            reset = 1'b0;
            start = 1'b0;
         end
         if (cyc == 15) begin
            reset = 1'b1;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("reset_mid_no_done", 64'(dones), 64'd0);
      check("reset_mid_idle", {busy, done, result_hi, result_lo}, 64'd0);

      run_op("mul_after_reset", MUL, 32'd7, 32'd6, 32'd0, 0,
             32'h0, 32'd42, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
